valrdy_normal_queue: RTL and testbench
======================================

Name: valrdy_normal_queue

Overview:
- Parameterized FIFO with val/rdy handshakes on both sides.
- Sits directly upstream of the enable/reset register stages. The queue's dequeue handshake (deq_val && deq_rdy) is the enable that a downstream register consumes, and deq_msg is its data.
- Normal queue: no enqueue-to-dequeue bypass, no dequeue-to-enqueue pipe path.
- Storage is a register file whose per-entry write enables are decoded from the enqueue handshake.

Parameters:
- p_nbits, 32, message width in bits.
- p_num_entries, 4, queue depth. Must be a power of two and at least 2.
- p_id, 0, instance identifier. Has no functional effect.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- reset  input  1  synchronous, active-high reset. Sampled on the rising clk edge.
- enq_val  input  1  upstream presents a valid message.
- enq_rdy  output  1  queue can accept a message this cycle.
- enq_msg  input  p_nbits  enqueue data.
- deq_val  output  1  queue holds a valid message at the head.
- deq_rdy  input  1  downstream accepts the head this cycle.
- deq_msg  output  p_nbits  head-of-queue data.
- num_free_entries  output  clog2(p_num_entries)+1  count of empty slots.

Behaviour:
- State:
  - enq_ptr and deq_ptr, each clog2(p_num_entries) bits.
  - count, clog2(p_num_entries)+1 bits, range 0..p_num_entries.
  - storage array of p_num_entries x p_nbits. Storage is not reset.
- Reset (reset=1 at a rising edge): enq_ptr=0, deq_ptr=0, count=0.
  - Outputs in the cycle after reset: enq_rdy=1, deq_val=0, num_free_entries=p_num_entries.
  - Reset overrides any concurrent handshake. No enqueue is written and no dequeue is counted.
  - Reset mid-operation discards all held messages.
- Combinational outputs, all derived from registered state only:
  - enq_rdy = (count != p_num_entries).
  - deq_val = (count != 0).
  - deq_msg = storage[deq_ptr]. Value is don't-care (may be X) while deq_val=0.
  - num_free_entries = p_num_entries - count.
  - enq_rdy does not depend on deq_rdy, and deq_val does not depend on enq_val. There are no combinational paths between the enqueue and dequeue sides.
- Handshakes:
  - do_enq = enq_val && enq_rdy.
  - do_deq = deq_val && deq_rdy.
- On a rising edge with reset=0:
  - If do_enq: storage[enq_ptr] <= enq_msg, and enq_ptr advances by 1.
  - If do_deq: deq_ptr advances by 1.
  - count <= count + do_enq - do_deq.
  - Simultaneous do_enq and do_deq leave count unchanged.
- Wrap-around: pointers increment modulo p_num_entries via natural overflow (power-of-two depth).
- Latency: a message enqueued at edge N appears on deq_msg with deq_val=1 in the cycle after edge N, i.e. one-cycle minimum latency.
- Boundary conditions:
  - Full (count=p_num_entries): enq_rdy=0 even if deq_rdy=1 in the same cycle. A slot freed by dequeue is visible the next cycle.
  - Empty (count=0): deq_val=0 even if enq_val=1. The message becomes visible the next cycle.
  - enq_val asserted while enq_rdy=0: no state change, and enq_msg is ignored.
- Ordering: strict FIFO. Messages are never dropped or duplicated.
- Assertions, checked every rising edge while reset=0:
  - enq_val and deq_rdy are not X.
  - count never exceeds p_num_entries.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then reset=0 with enq_val=0 and deq_rdy=0.
  - Required: enq_rdy=1, deq_val=0, num_free_entries=4, held for 5 cycles.
- Single message latency:
  - Stimulus: enq 0xDEADBEEF at cycle 0 with deq_rdy=1 throughout.
  - Required: deq_val=0 in cycle 0; deq_val=1 with deq_msg=0xDEADBEEF in cycle 1; deq_val=0 in cycle 2.
- Fill to full:
  - Stimulus: enq 0x1, 0x2, 0x3, 0x4 with deq_rdy=0, then enq_val=1 with 0x5.
  - Required: enq_rdy=0 and num_free_entries=0 after the fourth enqueue, and 0x5 is not accepted.
  - Then drain with deq_rdy=1. Required: deq_msg sequence is 1, 2, 3, 4.
- Full with simultaneous deq:
  - Stimulus: queue full; assert enq_val=1 (msg 0x9) and deq_rdy=1 in the same cycle.
  - Required: only the dequeue occurs that cycle; enq_rdy=1 next cycle; 0x9 is accepted then.
- Steady streaming with wrap:
  - Stimulus: enq_val=1 and deq_rdy=1 for 20 cycles with messages 0..19.
  - Required: in steady state count stays at 1, and output sequence is 0..19 in order across multiple pointer wraps.
- Reset mid-operation:
  - Stimulus: 3 entries held; assert reset=1 for 1 cycle with enq_val=1 and deq_rdy=1.
  - Required: next cycle deq_val=0 and num_free_entries=4; a following enq of 0xA is dequeued as 0xA.

Source files
------------

// File: rtl/valrdy_normal_queue.sv
// Normal val/rdy FIFO: no enq->deq bypass and no deq->enq pipe path.
// Ports: clk, reset, enq_{val,rdy,msg}, deq_{val,rdy,msg}, num_free_entries.
module valrdy_normal_queue #(
  parameter int p_nbits       = 32,
  parameter int p_num_entries = 4,
  parameter int p_id          = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enq_val,
  output logic                             enq_rdy,
  input  logic [p_nbits-1:0]               enq_msg,
  output logic                             deq_val,
  input  logic                             deq_rdy,
  output logic [p_nbits-1:0]               deq_msg,
  output logic [$clog2(p_num_entries):0]   num_free_entries
);

  localparam int AW = $clog2(p_num_entries);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(p_num_entries);

  logic [AW-1:0]      enq_ptr_q;
  logic [AW-1:0]      enq_ptr_d;
  logic [AW-1:0]      deq_ptr_q;
  logic [AW-1:0]      deq_ptr_d;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic [p_nbits-1:0] mem_q [p_num_entries];
  logic [p_num_entries-1:0] wen;
  logic               do_enq;
  logic               do_deq;

  // Status depends on registered count only, so the two sides
  // never see each other combinationally.
  assign enq_rdy          = (count_q != FULL);
  assign deq_val          = (count_q != '0);
  assign deq_msg          = mem_q[deq_ptr_q];
  assign num_free_entries = FULL - count_q;

  assign do_enq = enq_val && enq_rdy;
  assign do_deq = deq_val && deq_rdy;

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_enq) enq_ptr_d = enq_ptr_q + AW'(1);
    if (do_deq) deq_ptr_d = deq_ptr_q + AW'(1);
    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset blocks the write so a concurrent enqueue leaves no trace.
  always_comb begin
    wen = '0;
    if (do_enq && !reset) wen[enq_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_entries; i++) begin
      if (wen[i]) mem_q[i] <= enq_msg;
    end
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(enq_val) && !$isunknown(deq_rdy))
    else $error("queue %0d: X on enq_val/deq_rdy", p_id);

  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count_q <= FULL)
    else $error("queue %0d: count overflow", p_id);

endmodule

// File: tb/tb_valrdy_normal_queue.sv
// Scoreboard bench for valrdy_normal_queue.
// Stimulus pushes expected messages; a negedge monitor pops and compares.
module tb_valrdy_normal_queue;

  logic        clk;
  logic        reset;
  logic        enq_val;
  logic        enq_rdy;
  logic [31:0] enq_msg;
  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_msg;
  logic [2:0]  num_free_entries;

  int checks;
  int errors;
  logic [31:0] sbq [$];

  valrdy_normal_queue #(
    .p_nbits(32),
    .p_num_entries(4),
    .p_id(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enq_val(enq_val),
    .enq_rdy(enq_rdy),
    .enq_msg(enq_msg),
    .deq_val(deq_val),
    .deq_rdy(deq_rdy),
    .deq_msg(deq_msg),
    .num_free_entries(num_free_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: every accepted dequeue must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && deq_val === 1'b1 && deq_rdy === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected: got %h expected none", deq_msg);
      end else begin
        chk("deq_msg", deq_msg, sbq.pop_front());
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    enq_val = 1'b0;
    enq_msg = '0;
    deq_rdy = 1'b0;

    // Reset then idle
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_enq_rdy", 32'(enq_rdy), 32'd1);
      chk("idle_deq_val", 32'(deq_val), 32'd0);
      chk("idle_nfree", 32'(num_free_entries), 32'd4);
    end

    // Single message latency
    deq_rdy = 1'b1;
    enq_val = 1'b1;
    enq_msg = 32'hDEADBEEF;
    sbq.push_back(32'hDEADBEEF);
    settle();
    chk("lat_c0_deq_val", 32'(deq_val), 32'd0);
    step();
    enq_val = 1'b0;
    settle();
    chk("lat_c1_deq_val", 32'(deq_val), 32'd1);
    chk("lat_c1_deq_msg", deq_msg, 32'hDEADBEEF);
    step();
    settle();
    chk("lat_c2_deq_val", 32'(deq_val), 32'd0);
    deq_rdy = 1'b0;

    // Fill to full, offer a fifth, then drain
    for (int i = 1; i <= 4; i++) begin
      enq_val = 1'b1;
      enq_msg = 32'(i);
      sbq.push_back(32'(i));
      step();
    end
    enq_msg = 32'h5;
    settle();
    chk("full_enq_rdy", 32'(enq_rdy), 32'd0);
    chk("full_nfree", 32'(num_free_entries), 32'd0);
    step();
    step();
    settle();
    chk("full_hold_nfree", 32'(num_free_entries), 32'd0);
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    settle();
    chk("drain_deq_val", 32'(deq_val), 32'd0);
    chk("drain_nfree", 32'(num_free_entries), 32'd4);
    deq_rdy = 1'b0;

    // Full with simultaneous dequeue
    for (int i = 0; i < 4; i++) begin
      enq_val = 1'b1;
      enq_msg = 32'h11 + 32'(i);
      sbq.push_back(32'h11 + 32'(i));
      step();
    end
    enq_msg = 32'h9;
    deq_rdy = 1'b1;
    settle();
    chk("fsim_enq_rdy_c0", 32'(enq_rdy), 32'd0);
    step();
    settle();
    chk("fsim_enq_rdy_c1", 32'(enq_rdy), 32'd1);
    chk("fsim_nfree_c1", 32'(num_free_entries), 32'd1);
    sbq.push_back(32'h9);
    step();
    enq_val = 1'b0;
    settle();
    chk("fsim_nfree_c2", 32'(num_free_entries), 32'd1);
    for (int i = 0; i < 3; i++) step();
    settle();
    chk("fsim_drain_val", 32'(deq_val), 32'd0);

    // Steady streaming across pointer wraps
    deq_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_val = 1'b1;
      enq_msg = 32'(i);
      sbq.push_back(32'(i));
      settle();
      if (i > 0) begin
        chk("stream_nfree", 32'(num_free_entries), 32'd3);
        chk("stream_deq_val", 32'(deq_val), 32'd1);
      end
      step();
    end
    enq_val = 1'b0;
    step();
    settle();
    chk("stream_end_val", 32'(deq_val), 32'd0);
    deq_rdy = 1'b0;

    // Reset mid-operation discards held messages
    for (int i = 0; i < 3; i++) begin
      enq_val = 1'b1;
      enq_msg = 32'h21 + 32'(i);
      step();
    end
    settle();
    chk("pre_rst_nfree", 32'(num_free_entries), 32'd1);
    reset   = 1'b1;
    enq_msg = 32'h77;
    deq_rdy = 1'b1;
    step();
    reset   = 1'b0;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    settle();
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    chk("rst_nfree", 32'(num_free_entries), 32'd4);
    enq_val = 1'b1;
    enq_msg = 32'hA;
    sbq.push_back(32'hA);
    step();
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    step();
    settle();
    chk("rst_after_val", 32'(deq_val), 32'd0);
    deq_rdy = 1'b0;

    step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
